// File: rtl/uart_tx_8n1.sv
// 8-N-1 UART transmitter: start bit, 8 data bits LSB-first, stop bit.
// Each bit is held for BIT_PERIOD clocks, and all outputs are registered.
module uart_tx_8n1 #(
   parameter int BIT_PERIOD = 10
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       serial_out
);

   localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
   logic            r_busy;
   logic            r_done;
   logic            r_ser;
   logic            w_tick;

   assign w_tick     = (r_cnt == CW'(BIT_PERIOD - 1));
   assign tx_busy    = r_busy;
   assign tx_done    = r_done;
   assign serial_out = r_ser;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ser   <= 1'b1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_ser <= 1'b1;
               if (tx_start) begin
                  r_shift <= tx_data;
                  r_state <= START;
                  r_busy  <= 1'b1;
                  r_ser   <= 1'b0;
                  r_cnt   <= '0;
               end
            end
            START: begin
               if (w_tick) begin
                  r_cnt   <= '0;
                  r_state <= DATA;
                  r_ser   <= r_shift[0];
                  r_bit   <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            DATA: begin
               if (w_tick) begin
                  r_cnt <= '0;
                  // The line already carries r_shift[0], so the next bit is r_shift[1].
                  if (r_bit == 3'd7) begin
                     r_state <= STOP;
                     r_ser   <= 1'b1;
                  end else begin
                     r_shift <= r_shift >> 1;
                     r_ser   <= r_shift[1];
                     r_bit   <= r_bit + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            STOP: begin
               if (w_tick) begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_ser   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
